// File: rtl/bip_loader_pkg.sv
// Shared definitions for the BIP program loader: FSM state encoding, frame geometry
// and the address-width helper.
package bip_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 2;

  // Number of bits needed to represent value (0 for value <= 0).
  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Shifts accepted stream bytes MSB-first into an instruction word and pulses word_full
// for one cycle after the last byte of a word has been taken.
module loader_word_assembler import bip_loader_pkg::*; #(
  parameter int NB_BYTE = 8,
  parameter int NB_BITS = BYTES_PER_WORD * NB_BYTE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift,
  input  logic [NB_BYTE-1:0] data,
  output logic [NB_BITS-1:0] word,
  output logic               word_full
);

  localparam int NB_PHASE = clogb2(BYTES_PER_WORD - 1);
  localparam logic [NB_PHASE-1:0] LAST_PHASE = NB_PHASE'(BYTES_PER_WORD - 1);

  logic [NB_PHASE-1:0] phase_reg;
  logic [NB_BITS-1:0]  word_reg;
  logic                full_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= '0;
      word_reg  <= '0;
      full_reg  <= 1'b0;
    end else if (clr) begin
      // realign after a trailing odd byte (checksum) before the next frame
      phase_reg <= '0;
      full_reg  <= 1'b0;
    end else begin
      full_reg <= shift && (phase_reg == LAST_PHASE);
      if (shift) begin
        word_reg  <= {word_reg[NB_BITS-NB_BYTE-1:0], data};
        phase_reg <= (phase_reg == LAST_PHASE) ? '0 : phase_reg + NB_PHASE'(1);
      end
    end
  end

  assign word      = word_reg;
  assign word_full = full_reg;

endmodule

// File: rtl/bip_program_loader.sv
// Loads a length-prefixed byte stream into program memory and holds the CPU in reset until done.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the CPU.
module bip_program_loader import bip_loader_pkg::*; #(
  parameter int NB_BITS       = 16,
  parameter int NB_BYTE       = 8,
  parameter int INS_MEM_DEPTH = 2048,
  localparam int NB_ADDR      = clogb2(INS_MEM_DEPTH - 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_rx_ready,
  input  logic               i_load_req,
  output logic               o_mem_wr,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_BITS-1:0] o_mem_data,
  output logic               o_cpu_rst_n,
  output logic               o_done,
  output logic               o_error
);

  localparam int NB_LEN = LEN_BYTES * NB_BYTE;
  localparam int NB_CNT = NB_ADDR + 1;
  localparam logic [NB_LEN-1:0] DEPTH_LEN = NB_LEN'(INS_MEM_DEPTH);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t LAST_STATE = ST_CHECK;
`else
  localparam state_t LAST_STATE = ST_DONE;
`endif

  state_t              state_reg, state_next;
  logic [NB_CNT-1:0]   count_reg, count_next;
  logic [NB_LEN-1:0]   len_reg, len_next;
  logic [NB_BITS-1:0]  word;
  logic                word_full;
  logic                accept;
  logic                restart;
  logic [NB_LEN-1:0]   len_rx;

  assign accept  = i_rx_valid && o_rx_ready;
  assign restart = i_load_req && ((state_reg == ST_DONE) || (state_reg == ST_ERROR));
  // the high length byte is still sitting in the low byte of the assembler
  assign len_rx  = {word[NB_BYTE-1:0], i_rx_data};

  loader_word_assembler #(
    .NB_BYTE (NB_BYTE),
    .NB_BITS (NB_BITS)
  ) u_assembler (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .clr       (restart),
    .shift     (accept),
    .data      (i_rx_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg <= ST_LEN_HI;
      count_reg <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      len_reg   <= len_next;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0] csum_reg, csum_next;

  always_comb begin
    csum_next = csum_reg;
    if (restart)     csum_next = '0;
    else if (accept) csum_next = csum_reg ^ i_rx_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) csum_reg <= '0;
    else        csum_reg <= csum_next;
  end
`endif

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    len_next   = len_reg;
    case (state_reg)
      ST_LEN_HI:  if (accept) state_next = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          len_next = len_rx;
          if (len_rx == '0)            state_next = ST_DONE;
          else if (len_rx > DEPTH_LEN) state_next = ST_ERROR;
          else                         state_next = ST_DATA_HI;
        end
      end
      ST_DATA_HI: if (accept) state_next = ST_DATA_LO;
      ST_DATA_LO: if (accept) state_next = ST_WRITE;
      ST_WRITE: begin
        count_next = count_reg + NB_CNT'(1);
        state_next = (NB_LEN'(count_next) == len_reg) ? LAST_STATE : ST_DATA_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: if (accept) state_next = (i_rx_data == csum_reg) ? ST_DONE : ST_ERROR;
`endif
      ST_DONE, ST_ERROR: begin
        if (i_load_req) begin
          state_next = ST_LEN_HI;
          count_next = '0;
          len_next   = '0;
        end
      end
      default: state_next = ST_LEN_HI;
    endcase
  end

  always_comb begin
    o_rx_ready = 1'b0;
    case (state_reg)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK: o_rx_ready = 1'b1;
      default:                                                o_rx_ready = 1'b0;
    endcase
  end

  assign o_mem_wr    = (state_reg == ST_WRITE) && word_full;
  assign o_mem_addr  = count_reg[NB_ADDR-1:0];
  assign o_mem_data  = word;
  assign o_done      = (state_reg == ST_DONE);
  assign o_error     = (state_reg == ST_ERROR);
  assign o_cpu_rst_n = (state_reg == ST_DONE);

endmodule
